math_display_scan: RTL and testbench
====================================

# math_display_scan

Time-multiplexed four-digit seven-segment driver downstream of the 4-bit add/subtract stage. Each frame it snapshots A, B, AplusB and AminusB and scans them one digit at a time onto a common-anode display as hex characters. The snapshot keeps a frame from mixing old and new values; a hold input freezes the display.

## Interface
- REFRESH_DIV, default 100000: clock cycles each digit stays lit (legal values ≥ 2); counter width is clog2(REFRESH_DIV).
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  4  operand A.
- B  input  4  operand B.
- AplusB  input  4  sum from the math stage.
- AminusB  input  4  two's-complement difference from the math stage.
- hold  input  1  when high, the snapshot is not reloaded; scanning continues.
- seg  output  7  {g,f,e,d,c,b,a}, active-low, registered.
- dp  output  1  decimal point, active-low, registered.
- an  output  4  digit enables, active-low, one-hot-low, registered.

## Operation
- Prescaler `pcnt` counts 0 to REFRESH_DIV-1, then wraps to 0. `tick` = (pcnt == REFRESH_DIV-1).
- Digit index `dig` (2 bits) advances by 1 on each `tick` and wraps from 3 to 0. Mapping:
  - dig 0 → an=1110, shows AminusB.
  - dig 1 → an=1101, shows AplusB.
  - dig 2 → an=1011, shows B.
  - dig 3 → an=0111, shows A.
- Snapshot registers sA, sB, sP, sM load A, B, AplusB, AminusB on a `tick` whose next `dig` is 0, unless `hold` is 1.
- The digit-0 output computed on a loading edge uses the newly sampled values.
- Hex decode, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- dp = 1 (off) on all digits, except as described under Configuration.
- Reset values: pcnt=0; dig=3, so the first tick selects digit 0; snapshots=0; an=1111, seg=1111111, dp=1 (display fully blank).
- Reset asserted mid-scan blanks all outputs immediately (asynchronous). Scanning restarts from the reset state.

## Timing
- seg, dp and an change only on a `tick` edge. All three change on the same edge, so there is no ghosting between digits.
- After rst_n deasserts, the first non-blank output appears on the REFRESH_DIV-th rising edge. That edge shows digit 0 with the freshly snapshotted inputs.
- Each digit is lit for exactly REFRESH_DIV cycles. A full frame is 4·REFRESH_DIV cycles.
- Input-to-display latency: visible at the next frame start, i.e. at most 4·REFRESH_DIV cycles.
- Input changes within a frame never appear mid-frame.
- `hold` is sampled only on loading edges. A hold pulse that does not cover a loading edge has no effect.

## Configuration
- SIGNED_DIFF_EN defined:
  - Digit 0 shows the magnitude of sM as a signed 4-bit value: |sM|; 1000 shows 8.
  - dp on digit 0 is 0 (lit) when sM[3]=1.
  - All other digits are unchanged.
- SIGNED_DIFF_EN undefined:
  - Digit 0 shows raw sM in hex.
  - dp stays 1 on every digit.

## Test plan
- Reset behaviour (REFRESH_DIV=4): hold rst_n low, then release. Outputs must be an=1111, seg=1111111, dp=1 until the 4th edge; then an=1110.
- Scan sequence: A=3, B=1, AplusB=4, AminusB=2. Digits must appear in order 0,1,2,3:
  - digit 0: seg=0100100.
  - digit 1: seg=0011001.
  - digit 2: seg=1111001.
  - digit 3: seg=0110000.
  - Each digit lasts 4 cycles and an cycles 1110→1101→1011→0111.
- Snapshot integrity: change A from 3 to F while dig=1. Digit 3 of the same frame must still show 3 (0110000). The next frame must show F (0001110).
- Hold: hold=1 across a frame boundary while AplusB changes from 4 to 8. The display must keep 4. Set hold=0: the next frame shows 8 (0000000).
- SIGNED_DIFF_EN build: AminusB=1110. Digit 0 must show 2 (0100100) with dp=0. With AminusB=1000 it must show 8 with dp=0. Without the macro, AminusB=1110 shows E (0000110) with dp=1.
- Async reset mid-scan: assert rst_n low between clock edges while dig=2. an must go to 1111 without waiting for a clock edge. After release, digit 0 appears on the 4th edge.

Source files
------------

// File: rtl/math_display_scan_if.sv
// Bus between the add/subtract stage and the seven-segment scanner:
// operand/result inputs and hold on one side, registered display drive on the other.
interface math_display_scan_if;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] AplusB;
    logic [3:0] AminusB;
    logic       hold;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    modport master (
        output A, B, AplusB, AminusB, hold,
        input  seg, dp, an
    );

    modport slave (
        input  A, B, AplusB, AminusB, hold,
        output seg, dp, an
    );
endinterface

// File: rtl/math_display_scan.sv
// Four-digit common-anode hex scanner for A, B, A+B and A-B with per-frame snapshot and hold.
// Optional build macro SIGNED_DIFF_EN: digit 0 shows |A-B| with the decimal point marking a negative result.
module math_display_scan #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic                clk,
    input  logic                rst_n,
    math_display_scan_if.slave  bus,
    output logic [1:0]          dbg_dig
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] pcnt;
    logic [1:0]    dig;
    logic [3:0]    s_a, s_b, s_p, s_m;

    logic          tick;
    logic [1:0]    dig_next;
    logic          load;
    logic [3:0]    n_a, n_b, n_p, n_m;
    logic [3:0]    val;
    logic          dp_next;
    logic [3:0]    an_next;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign tick    = (pcnt == LAST);
    assign dbg_dig = dig;

    // Outputs are computed for the digit being entered; on a loading edge the
    // freshly sampled inputs bypass the snapshot so digit 0 is never stale.
    always_comb begin
        dig_next = dig + 2'd1;
        load     = tick && (dig_next == 2'd0) && !bus.hold;
        n_a      = load ? bus.A       : s_a;
        n_b      = load ? bus.B       : s_b;
        n_p      = load ? bus.AplusB  : s_p;
        n_m      = load ? bus.AminusB : s_m;
        dp_next  = 1'b1;
        case (dig_next)
            2'd0:    val = n_m;
            2'd1:    val = n_p;
            2'd2:    val = n_b;
            default: val = n_a;
        endcase
`ifdef SIGNED_DIFF_EN
        if (dig_next == 2'd0) begin
            val     = n_m[3] ? (4'd0 - n_m) : n_m;
            dp_next = ~n_m[3];
        end
`endif
        an_next = ~(4'b0001 << dig_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt    <= '0;
            dig     <= 2'd3;
            s_a     <= 4'd0;
            s_b     <= 4'd0;
            s_p     <= 4'd0;
            s_m     <= 4'd0;
            bus.seg <= 7'b1111111;
            bus.dp  <= 1'b1;
            bus.an  <= 4'b1111;
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            if (tick) begin
                dig     <= dig_next;
                bus.seg <= hex7(val);
                bus.dp  <= dp_next;
                bus.an  <= an_next;
            end
            if (load) begin
                s_a <= bus.A;
                s_b <= bus.B;
                s_p <= bus.AplusB;
                s_m <= bus.AminusB;
            end
        end
    end

endmodule

// File: tb/tb_math_display_scan.sv
// Bench for math_display_scan: directed scan/snapshot/hold/reset scenarios, then random
// operand and hold traffic, all compared every cycle against a frame-timeline model.
module tb_math_display_scan;

  localparam int N = 4;

  logic clk;
  logic rst_n;
  logic [1:0] dbg_dig;
  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  math_display_scan_if bus ();

  math_display_scan #(.REFRESH_DIV(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .dbg_dig (dbg_dig)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0] font [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  int cyc;
  logic [3:0] m_a, m_b, m_p, m_m;

  // cyc = rising edges since reset release; frames start at N, 5N, 9N, ...
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0;
      m_a <= 4'd0; m_b <= 4'd0; m_p <= 4'd0; m_m <= 4'd0;
    end else begin
      cyc <= cyc + 1;
      if ((cyc + 1) >= N && ((cyc + 1 - N) % (4 * N)) == 0 && !bus.hold) begin
        m_a <= bus.A; m_b <= bus.B; m_p <= bus.AplusB; m_m <= bus.AminusB;
      end
    end
  end

  function automatic logic [11:0] exp_out();
    int d;
    int v;
    logic dpv;
    if (cyc < N) return 12'hFFF;
    d = ((cyc - N) / N) % 4;
    dpv = 1'b1;
    case (d)
      0: v = int'(m_m);
      1: v = int'(m_p);
      2: v = int'(m_b);
      default: v = int'(m_a);
    endcase
`ifdef SIGNED_DIFF_EN
    if (d == 0) begin
      v = (m_m >= 4'd8) ? 16 - int'(m_m) : int'(m_m);
      dpv = ~m_m[3];
    end
`endif
    return {~(4'b0001 << d), dpv, font[v]};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) check("frame", {4'd0, bus.an, bus.dp, bus.seg}, {4'd0, exp_out()});
  end

  // ---------------- driver tasks ----------------
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [3:0] a, input logic [3:0] b);
    bus.A = a;
    bus.B = b;
    bus.AplusB = a + b;
    bus.AminusB = a - b;
  endtask

  task automatic check_digit(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e);
    check({tag, "_an"}, 16'(bus.an), 16'(an_e));
    check({tag, "_seg"}, 16'(bus.seg), 16'(seg_e));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    bus.hold = 1'b0;
    set_ops(4'd3, 4'd1);
    bus.AplusB = 4'd4;
    bus.AminusB = 4'd2;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1;
    check("rst_an", 16'(bus.an), 16'hF);
    check("rst_seg", 16'(bus.seg), 16'h7F);
    check("rst_dp", 16'(bus.dp), 16'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // edge counting below is relative to this release
    wait_edges(3);
    check("pre_first_an", 16'(bus.an), 16'hF);
    wait_edges(1);
    check_digit("d0", 4'b1110, 7'b0100100);
    wait_edges(4);
    check_digit("d1", 4'b1101, 7'b0011001);
    bus.A = 4'hF;
    wait_edges(4);
    check_digit("d2", 4'b1011, 7'b1111001);
    wait_edges(4);
    check_digit("d3_old", 4'b0111, 7'b0110000);
    wait_edges(16);
    check_digit("d3_new", 4'b0111, 7'b0001110);

    // hold across frame boundary at edge 36
    bus.hold = 1'b1;
    bus.AplusB = 4'd8;
    wait_edges(8);
    check_digit("hold_d1", 4'b1101, 7'b0011001);
    bus.hold = 1'b0;
    wait_edges(16);
    check_digit("unhold_d1", 4'b1101, 7'b0000000);

    bus.AminusB = 4'b1110;
    wait_edges(12);
`ifdef SIGNED_DIFF_EN
    check_digit("neg2", 4'b1110, 7'b0100100);
    check("neg2_dp", 16'(bus.dp), 16'h0);
`else
    check_digit("rawE", 4'b1110, 7'b0000110);
    check("rawE_dp", 16'(bus.dp), 16'h1);
`endif
    bus.AminusB = 4'b1000;
    wait_edges(16);
    check_digit("neg8", 4'b1110, 7'b0000000);
`ifdef SIGNED_DIFF_EN
    check("neg8_dp", 16'(bus.dp), 16'h0);
`else
    check("neg8_dp", 16'(bus.dp), 16'h1);
`endif

    // async reset between edges while digit 2 is lit
    wait_edges(8);
    check("pre_rst_an", 16'(bus.an), 16'b1011);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_an", 16'(bus.an), 16'hF);
    check("async_seg", 16'(bus.seg), 16'h7F);
    check("async_dp", 16'(bus.dp), 16'h1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_edges(3);
    check("post_rst_blank", 16'(bus.an), 16'hF);
    wait_edges(1);
    check("post_rst_an", 16'(bus.an), 16'b1110);

    // random operands and hold; model checks every cycle
    for (int i = 0; i < 1500; i++) begin
      wait_edges(1);
      if ($urandom_range(0, 7) == 0) set_ops(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 5) == 0) bus.hold = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 400) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("rand_async_an", 16'(bus.an), 16'hF);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    wait_edges(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
